// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB bundle, ID read ports and commit export for wb_regfile
interface wb_regfile_if;
  logic        WB_RegWrite;
  logic        WB_MemIOtoReg;
  logic        WB_Mfhi;
  logic        WB_Mflo;
  logic        WB_Mthi;
  logic        WB_Mtlo;
  logic        WB_Jal;
  logic        WB_Jalr;
  logic        WB_Bgezal;
  logic        WB_Bltzal;
  logic        WB_Negative;
  logic [31:0] WB_opcplus4;
  logic [31:0] WB_ALU_Result;
  logic [31:0] WB_MemData;
  logic [4:0]  WB_waddr;
  logic        md_write;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] hi_value;
  logic [31:0] lo_value;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  modport master (
    output WB_RegWrite, WB_MemIOtoReg, WB_Mfhi, WB_Mflo, WB_Mthi, WB_Mtlo,
           WB_Jal, WB_Jalr, WB_Bgezal, WB_Bltzal, WB_Negative,
           WB_opcplus4, WB_ALU_Result, WB_MemData, WB_waddr,
           md_write, md_hi, md_lo, raddr1, raddr2,
    input  rdata1, rdata2, hi_value, lo_value, wb_we, wb_waddr, wb_wdata
  );

  modport slave (
    input  WB_RegWrite, WB_MemIOtoReg, WB_Mfhi, WB_Mflo, WB_Mthi, WB_Mtlo,
           WB_Jal, WB_Jalr, WB_Bgezal, WB_Bltzal, WB_Negative,
           WB_opcplus4, WB_ALU_Result, WB_MemData, WB_waddr,
           md_write, md_hi, md_lo, raddr1, raddr2,
    output rdata1, rdata2, hi_value, lo_value, wb_we, wb_waddr, wb_wdata
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 32x32 GPR file with write-through reads, HI/LO pair
module wb_regfile (
  input  logic         clock,
  input  logic         reset,
  wb_regfile_if.slave  bus
);
  logic [31:0] regs_q [32];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        link_taken;
  logic        link_cond;
  logic        we_d;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;

  always_comb begin
    link_taken = bus.WB_Jal | bus.WB_Jalr
               | (bus.WB_Bgezal & ~bus.WB_Negative)
               | (bus.WB_Bltzal &  bus.WB_Negative);
    link_cond  = bus.WB_Bgezal | bus.WB_Bltzal;

    // Jalr links into its own rd; the other link forms always target $31.
    waddr_d = bus.WB_waddr;
    if (bus.WB_Jal | bus.WB_Bgezal | bus.WB_Bltzal)
      waddr_d = 5'd31;

    wdata_d = bus.WB_ALU_Result;
    if (link_taken)             wdata_d = bus.WB_opcplus4;
    else if (bus.WB_Mfhi)       wdata_d = hi_q;
    else if (bus.WB_Mflo)       wdata_d = lo_q;
    else if (bus.WB_MemIOtoReg) wdata_d = bus.WB_MemData;

    we_d = bus.WB_RegWrite & ~(link_cond & ~link_taken) & (waddr_d != 5'd0);
  end

  // The multiply/divide result belongs to the younger EX instruction, so it overrides mthi/mtlo.
  always_comb begin
    hi_d = hi_q;
    if (bus.md_write)     hi_d = bus.md_hi;
    else if (bus.WB_Mthi) hi_d = bus.WB_ALU_Result;
    lo_d = lo_q;
    if (bus.md_write)     lo_d = bus.md_lo;
    else if (bus.WB_Mtlo) lo_d = bus.WB_ALU_Result;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (we_d) regs_q[waddr_d] <= wdata_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    if (bus.raddr1 == 5'd0)                      bus.rdata1 = 32'd0;
    else if (we_d && (bus.raddr1 == waddr_d))    bus.rdata1 = wdata_d;
    else                                         bus.rdata1 = regs_q[bus.raddr1];

    if (bus.raddr2 == 5'd0)                      bus.rdata2 = 32'd0;
    else if (we_d && (bus.raddr2 == waddr_d))    bus.rdata2 = wdata_d;
    else                                         bus.rdata2 = regs_q[bus.raddr2];
  end

  assign bus.hi_value = hi_q;
  assign bus.lo_value = lo_q;
  assign bus.wb_we    = we_d;
  assign bus.wb_waddr = waddr_d;
  assign bus.wb_wdata = wdata_d;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile with directed vectors
module tb_wb_regfile;
  logic clock;
  logic reset;
  wb_regfile_if bus ();

  wb_regfile dut (.clock(clock), .reset(reset), .bus(bus.slave));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   vectors;
  int   miscompares;
  bit   done;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return bus.rdata1;
      1: return bus.rdata2;
      2: return bus.hi_value;
      3: return bus.lo_value;
      4: return {31'd0, bus.wb_we};
      5: return {27'd0, bus.wb_waddr};
      default: return bus.wb_wdata;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = q.pop_front();
        a = actual(e.sel);
        vectors++;
        if (a !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %08h expected %08h", e.name, a, e.exp);
        end
      end
    end
  end

  task automatic push_exp(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    bus.WB_RegWrite = 0; bus.WB_MemIOtoReg = 0; bus.WB_Mfhi = 0; bus.WB_Mflo = 0;
    bus.WB_Mthi = 0; bus.WB_Mtlo = 0; bus.WB_Jal = 0; bus.WB_Jalr = 0;
    bus.WB_Bgezal = 0; bus.WB_Bltzal = 0; bus.WB_Negative = 0;
    bus.WB_opcplus4 = 0; bus.WB_ALU_Result = 0; bus.WB_MemData = 0; bus.WB_waddr = 0;
    bus.md_write = 0; bus.md_hi = 0; bus.md_lo = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; done = 0;
    clr();
    bus.raddr1 = 0; bus.raddr2 = 0;
    reset = 1'b0;
    push_exp(2, 32'h0, "reset_hi");
    push_exp(3, 32'h0, "reset_lo");
    push_exp(0, 32'h0, "reset_r0");
    step();
    reset = 1'b1;

    bus.WB_RegWrite = 1; bus.WB_waddr = 5; bus.WB_ALU_Result = 32'h1234;
    bus.md_write = 1; bus.md_hi = 32'hFF; bus.md_lo = 32'h3;
    step();
    clr(); bus.raddr1 = 5;
    push_exp(0, 32'h1234, "seed_r5");
    push_exp(2, 32'hFF, "seed_hi");
    step();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL direct_async_r5: got %08h expected 00000000", bus.rdata1);
    end
    vectors++;
    if (bus.hi_value !== 32'h0) begin
      miscompares++;
      $display("FAIL direct_async_hi: got %08h expected 00000000", bus.hi_value);
    end
    push_exp(0, 32'h0, "async_rst_r5");
    push_exp(2, 32'h0, "async_rst_hi");
    push_exp(3, 32'h0, "async_rst_lo");
    step();
    reset = 1'b1;

    bus.WB_RegWrite = 1; bus.WB_waddr = 8; bus.WB_ALU_Result = 32'hDEADBEEF; bus.raddr1 = 8;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL direct_bypass_r8: got %08h expected deadbeef", bus.rdata1);
    end
    push_exp(0, 32'hDEADBEEF, "bypass_r8");
    push_exp(4, 32'h1, "we_r8");
    push_exp(5, 32'd8, "waddr_r8");
    step();
    clr();
    push_exp(0, 32'hDEADBEEF, "array_r8");
    step();

    bus.WB_RegWrite = 1; bus.WB_waddr = 0; bus.WB_ALU_Result = 32'h12345678; bus.raddr1 = 0;
    #1;
    vectors++;
    if (bus.wb_we !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_we_r0: got %0b expected 0", bus.wb_we);
    end
    push_exp(4, 32'h0, "we_r0");
    push_exp(0, 32'h0, "read_r0_wr");
    step();
    clr();
    push_exp(0, 32'h0, "read_r0_after");
    step();

    bus.WB_RegWrite = 1; bus.WB_Bgezal = 1; bus.WB_Negative = 0; bus.WB_waddr = 7;
    bus.WB_opcplus4 = 32'h100; bus.WB_ALU_Result = 32'h999; bus.raddr2 = 31;
    push_exp(4, 32'h1, "bgezal_we");
    push_exp(5, 32'd31, "bgezal_waddr");
    push_exp(6, 32'h100, "bgezal_wdata");
    push_exp(1, 32'h100, "bgezal_bypass");
    step();
    clr();
    push_exp(1, 32'h100, "bgezal_r31");
    step();

    bus.WB_RegWrite = 1; bus.WB_Bgezal = 1; bus.WB_Negative = 1; bus.WB_opcplus4 = 32'h200;
    #1;
    vectors++;
    if (bus.wb_we !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_bgezal_nt_we: got %0b expected 0", bus.wb_we);
    end
    push_exp(4, 32'h0, "bgezal_nt_we");
    push_exp(1, 32'h100, "bgezal_nt_nobyp");
    step();
    clr();
    push_exp(1, 32'h100, "bgezal_nt_r31");
    step();

    bus.WB_RegWrite = 1; bus.WB_Bltzal = 1; bus.WB_Negative = 1; bus.WB_opcplus4 = 32'h300;
    step();
    clr();
    push_exp(1, 32'h300, "bltzal_r31");
    step();

    bus.WB_RegWrite = 1; bus.WB_Jalr = 1; bus.WB_waddr = 9; bus.WB_opcplus4 = 32'h444;
    push_exp(5, 32'd9, "jalr_waddr");
    step();
    clr(); bus.raddr1 = 9;
    push_exp(0, 32'h444, "jalr_r9");
    step();

    bus.WB_RegWrite = 1; bus.WB_Jal = 1; bus.WB_Mfhi = 1; bus.WB_waddr = 2; bus.WB_opcplus4 = 32'h888;
    push_exp(5, 32'd31, "jal_waddr");
    push_exp(6, 32'h888, "jal_over_mfhi");
    step();
    clr();

    bus.WB_Mthi = 1; bus.WB_ALU_Result = 32'hA5A5A5A5;
    bus.md_write = 1; bus.md_hi = 32'h11; bus.md_lo = 32'h22;
    step();
    clr();
    push_exp(2, 32'h11, "md_over_mthi");
    push_exp(3, 32'h22, "md_lo");
    bus.WB_Mthi = 1; bus.WB_ALU_Result = 32'hA5A5A5A5;
    push_exp(2, 32'h11, "mthi_not_yet");
    step();
    clr();
    push_exp(2, 32'hA5A5A5A5, "mthi_hi");
    push_exp(3, 32'h22, "mthi_lo_kept");
    step();

    bus.WB_RegWrite = 1; bus.WB_Mfhi = 1; bus.WB_waddr = 3;
    push_exp(6, 32'hA5A5A5A5, "mfhi_wdata");
    step();
    clr(); bus.raddr1 = 3;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL direct_mfhi_r3: got %08h expected a5a5a5a5", bus.rdata1);
    end
    push_exp(0, 32'hA5A5A5A5, "mfhi_r3");
    step();

    bus.WB_RegWrite = 1; bus.WB_MemIOtoReg = 1; bus.WB_MemData = 32'h55;
    bus.WB_ALU_Result = 32'h66; bus.WB_waddr = 4;
    step();
    clr(); bus.raddr1 = 4;
    push_exp(0, 32'h55, "mem_r4");
    bus.WB_Mtlo = 1; bus.WB_ALU_Result = 32'h77;
    step();
    clr();
    push_exp(3, 32'h77, "mtlo_lo");
    bus.WB_RegWrite = 1; bus.WB_Mflo = 1; bus.WB_MemIOtoReg = 1;
    bus.WB_MemData = 32'h55; bus.WB_waddr = 4;
    push_exp(6, 32'h77, "mflo_over_mem");
    step();
    clr();
    push_exp(0, 32'h77, "mflo_r4");
    step();

    bus.WB_Mthi = 1; bus.WB_Mtlo = 1; bus.WB_ALU_Result = 32'hC3;
    step();
    clr();
    push_exp(2, 32'hC3, "both_hi");
    push_exp(3, 32'hC3, "both_lo");
    step();
    step();

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: got unchecked expected %08h", e.name, e.exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
